// File: rtl/dac_spi_mc.sv
// rtl/dac_spi_mc.sv - multi-channel DAC SPI writer, one frame per changed channel, round-robin
module dac_spi_mc #(
    parameter int                NUM_CH   = 4,
    parameter int                DATA_W   = 14,
    parameter int                CMD_W    = 4,
    parameter logic [CMD_W-1:0]  CMD      = 'h3,
    parameter int                ADDR_W   = 4,
    parameter int                FRAME_W  = 24,
    parameter int                HALF_DIV = 8,
    parameter int                SYNC_GAP = 8
) (
    input  logic                                               i_clk,
    input  logic                                               i_rst,
    input  logic [NUM_CH*DATA_W-1:0]                           i_data_dac,
    input  logic                                               i_force_upd,
    output logic                                               o_sclk,
    output logic                                               o_mosi,
    output logic                                               o_sync_n,
    output logic                                               o_busy,
    output logic                                               o_frame_done,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]     o_cur_ch
);

    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int HDR_W   = CMD_W + ADDR_W + DATA_W;
    localparam int PAD_W   = FRAME_W - HDR_W;
    localparam int CNT_MAX = (2 * HALF_DIV > SYNC_GAP) ? 2 * HALF_DIV : SYNC_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(FRAME_W + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SYNC_PRE = 3'd1;
    localparam logic [2:0] S_DATA     = 3'd2;
    localparam logic [2:0] S_SYNC_END = 3'd3;
    localparam logic [2:0] S_GAP      = 3'd4;

    logic [2:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [FRAME_W-1:0] r_shift;
    logic [DATA_W-1:0]  r_shadow [NUM_CH];
    logic [NUM_CH-1:0]  r_fpend;
    logic [CH_W-1:0]    r_rr_ptr;
    logic [CH_W-1:0]    r_cur_ch;
    logic               r_sclk;
    logic               r_sync_n;
    logic               r_frame_done;

    logic [NUM_CH-1:0]  w_pending;
    logic               w_any;
    logic [CH_W-1:0]    w_sel;
    logic [DATA_W-1:0]  w_slice;
    logic [HDR_W-1:0]   w_hdr;
    logic [FRAME_W-1:0] w_frame;
    logic               w_lo;
    logic               w_hi;

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_pending[i] = (i_data_dac[i*DATA_W +: DATA_W] != r_shadow[i]) | r_fpend[i];
        end
    end

    // First pending channel at or after the round-robin pointer, wrapping.
    always_comb begin
        int v_idx;
        v_idx = 0;
        w_any = 1'b0;
        w_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            v_idx = (int'(r_rr_ptr) + k) % NUM_CH;
            if (!w_any && w_pending[v_idx]) begin
                w_any = 1'b1;
                w_sel = CH_W'(v_idx);
            end
        end
    end

    assign w_slice = i_data_dac[w_sel*DATA_W +: DATA_W];
    assign w_hdr   = {CMD, ADDR_W'(w_sel), w_slice};
    assign w_frame = FRAME_W'(w_hdr) << PAD_W;

    assign w_lo = (r_cnt == CNT_W'(HALF_DIV - 1));
    assign w_hi = (r_cnt == CNT_W'(2 * HALF_DIV - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_fpend      <= '0;
            r_rr_ptr     <= '0;
            r_cur_ch     <= '0;
            r_sclk       <= 1'b1;
            r_sync_n     <= 1'b1;
            r_frame_done <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_any) begin
                        r_shadow[w_sel] <= w_slice;
                        r_shift         <= w_frame;
                        r_fpend[w_sel]  <= 1'b0;
                        r_cur_ch        <= w_sel;
                        r_rr_ptr        <= (w_sel == CH_W'(NUM_CH - 1)) ? '0 : w_sel + 1'b1;
                        r_bit_cnt       <= '0;
                        r_state         <= S_SYNC_PRE;
                    end
                end
                S_SYNC_PRE: begin
                    if (w_hi) begin
                        r_sync_n <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_lo) begin
                        r_sclk <= 1'b0;
                    end
                    // mosi only moves on the sclk rising edge, so the DAC samples a settled bit.
                    if (w_hi) begin
                        r_sclk  <= 1'b1;
                        r_shift <= r_shift << 1;
                        r_cnt   <= '0;
                        if (r_bit_cnt == BIT_W'(FRAME_W - 1)) begin
                            r_state <= S_SYNC_END;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SYNC_END: begin
                    if (w_lo) begin
                        r_sync_n <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == '0) begin
                        r_frame_done <= 1'b1;
                    end
                    if (r_cnt == CNT_W'(SYNC_GAP - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt    <= '0;
                    r_sclk   <= 1'b1;
                    r_sync_n <= 1'b1;
                    r_state  <= S_IDLE;
                end
            endcase
            // A force request on the launch edge must survive the launch clear.
            if (i_force_upd) begin
                r_fpend <= '1;
            end
        end
    end

    assign o_sclk       = r_sclk;
    assign o_mosi       = r_shift[FRAME_W-1];
    assign o_sync_n     = r_sync_n;
    assign o_busy       = (r_state != S_IDLE);
    assign o_frame_done = r_frame_done;
    assign o_cur_ch     = r_cur_ch;

endmodule
